// File: rtl/tqvp_bus_arbiter.sv
// Serialises two requesters (SPI bridge m0, command sequencer m1) onto one TinyQV peripheral bus.
// Registered one-cycle strobes; reads wait for data_ready up to TIMEOUT cycles, then abort with err.
module tqvp_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_txn,
  input  logic [5:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_txn,
  input  logic [5:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic        grant_id,
  output logic        busy,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  state_e state_q, state_d;

  logic          we_q, we_d;
  logic [1:0]    txn_q, txn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic [5:0]    address_q, address_d;
  logic [31:0]   data_in_q, data_in_d;
  logic [1:0]    wr_n_q, wr_n_d;
  logic [1:0]    rd_n_q, rd_n_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic          busy_q, busy_d;

  logic          any_req, win, sel_we, fin_err;
  logic [1:0]    sel_txn;
  logic [5:0]    sel_addr;
  logic [31:0]   sel_wdata, rd_masked;

  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    else                  win = m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_txn   = win ? m1_txn   : m0_txn;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  // Narrow reads only return the bytes the transaction actually covers.
  always_comb begin
    case (txn_q)
      2'b00:   rd_masked = {24'h0, data_out[7:0]};
      2'b01:   rd_masked = {16'h0, data_out[15:0]};
      default: rd_masked = data_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = (sel_txn == 2'b11) ? DONE : ISSUE;
      ISSUE:   state_d = (we_q || data_ready) ? DONE : WAIT;
      WAIT:    if (data_ready || cnt_q == CW'(TIMEOUT - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    txn_d        = txn_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    address_d    = address_q;
    data_in_d    = data_in_q;
    rdata_d      = rdata_q;
    wr_n_d       = 2'b11;
    rd_n_d       = 2'b11;
    fin_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = win;
          last_grant_d = win;
          we_d         = sel_we;
          txn_d        = sel_txn;
          rdata_d      = '0;
          if (sel_txn == 2'b11) begin
            fin_err = 1'b1;
          end else begin
            address_d = sel_addr;
            data_in_d = sel_wdata;
            if (sel_we) wr_n_d = sel_txn;
            else        rd_n_d = sel_txn;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (!we_q && data_ready) rdata_d = rd_masked;
      end
      WAIT: begin
        if (data_ready)                         rdata_d = rd_masked;
        else if (cnt_q == CW'(TIMEOUT - 1))     fin_err = 1'b1;
        else                                    cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
    // DONE is only ever entered for one cycle, so the ack is a single pulse.
    ack0_d = (state_d == DONE) && !grant_d;
    ack1_d = (state_d == DONE) &&  grant_d;
    err0_d = ack0_d && fin_err;
    err1_d = ack1_d && fin_err;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      txn_q        <= 2'b00;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      address_q    <= '0;
      data_in_q    <= '0;
      wr_n_q       <= 2'b11;
      rd_n_q       <= 2'b11;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q         <= we_d;
      txn_q        <= txn_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack       = ack0_q;
  assign m0_err       = err0_q;
  assign m1_ack       = ack1_q;
  assign m1_err       = err1_q;
  assign rdata        = rdata_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = wr_n_q;
  assign data_read_n  = rd_n_q;

endmodule
